// File: rtl/conv_seq_if.sv
// Handshake and address bundle between the convolution sequencer and its datapath/consumer.
interface conv_seq_if #(
   parameter int unsigned N = 5,
   parameter int unsigned M = 3
);
   localparam int unsigned IW = (N * N > 1) ? $clog2(N * N) : 1;
   localparam int unsigned KW = (M * M > 1) ? $clog2(M * M) : 1;
   localparam int unsigned RW = (N - M + 1 > 1) ? $clog2(N - M + 1) : 1;

   logic          start;
   logic          busy;
   logic          done;
   logic          tap_en;
   logic          tap_first;
   logic          tap_last;
   logic [IW-1:0] img_addr;
   logic [KW-1:0] ker_addr;
   logic          res_valid;
   logic          res_ready;
   logic [RW-1:0] res_row;
   logic [RW-1:0] res_col;

   modport master (
      input  start, res_ready,
      output busy, done, tap_en, tap_first, tap_last,
             img_addr, ker_addr, res_valid, res_row, res_col
   );

   modport slave (
      output start, res_ready,
      input  busy, done, tap_en, tap_first, tap_last,
             img_addr, ker_addr, res_valid, res_row, res_col
   );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Sequencer for a 2-D valid convolution: walks every window and tap, waits out the
// datapath latency, then presents each window sum under a valid/ready handshake.
module conv_seq_ctrl #(
   parameter int unsigned N   = 5,
   parameter int unsigned M   = 3,
   parameter int unsigned LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   conv_seq_if.master  bus
);
   localparam int unsigned IW    = (N * N > 1) ? $clog2(N * N) : 1;
   localparam int unsigned KW    = (M * M > 1) ? $clog2(M * M) : 1;
   localparam int unsigned RW    = (N - M + 1 > 1) ? $clog2(N - M + 1) : 1;
   localparam int unsigned PW    = (M > 1) ? $clog2(M) : 1;
   localparam int unsigned DW    = (LAT > 1) ? $clog2(LAT) : 1;
   localparam int unsigned WMAX  = N - M;
   localparam int unsigned DLAST = (LAT > 0) ? LAT - 1 : 0;
   localparam int unsigned QPEN  = (M > 1) ? M - 2 : 0;

   typedef enum logic [2:0] {IDLE, RUN, DRAIN, HOLD, DONE} state_t;

   state_t        state;
   logic [RW-1:0] k, l;
   logic [PW-1:0] p, q;
   logic [DW-1:0] d;
   logic          last_tap;

   assign last_tap = (p == PW'(M - 1)) && (q == PW'(M - 1));

   function automatic logic [IW-1:0] img_at(input logic [RW-1:0] kk, input logic [PW-1:0] pp,
                                            input logic [RW-1:0] ll, input logic [PW-1:0] qq);
      return IW'((32'(kk) + 32'(pp)) * N + 32'(ll) + 32'(qq));
   endfunction

   function automatic logic [KW-1:0] ker_at(input logic [PW-1:0] pp, input logic [PW-1:0] qq);
      return KW'(32'(pp) * M + 32'(qq));
   endfunction

   // Outputs are registered alongside the state so they always describe the current state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         k             <= '0;
         l             <= '0;
         p             <= '0;
         q             <= '0;
         d             <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.tap_en    <= 1'b0;
         bus.tap_first <= 1'b0;
         bus.tap_last  <= 1'b0;
         bus.img_addr  <= '0;
         bus.ker_addr  <= '0;
         bus.res_valid <= 1'b0;
         bus.res_row   <= '0;
         bus.res_col   <= '0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state         <= RUN;
                  k             <= '0;
                  l             <= '0;
                  p             <= '0;
                  q             <= '0;
                  bus.busy      <= 1'b1;
                  bus.tap_en    <= 1'b1;
                  bus.tap_first <= 1'b1;
                  bus.tap_last  <= (M == 1);
                  bus.img_addr  <= '0;
                  bus.ker_addr  <= '0;
               end
            end
            RUN: begin
               bus.tap_first <= 1'b0;
               if (last_tap) begin
                  bus.tap_en   <= 1'b0;
                  bus.tap_last <= 1'b0;
                  d            <= '0;
                  if (LAT > 0) begin
                     state <= DRAIN;
                  end else begin
                     state         <= HOLD;
                     bus.res_valid <= 1'b1;
                     bus.res_row   <= k;
                     bus.res_col   <= l;
                  end
               end else if (q == PW'(M - 1)) begin
                  p            <= p + PW'(1);
                  q            <= '0;
                  bus.tap_last <= 1'b0;
                  bus.img_addr <= img_at(k, p + PW'(1), l, '0);
                  bus.ker_addr <= ker_at(p + PW'(1), '0);
               end else begin
                  q            <= q + PW'(1);
                  bus.tap_last <= (p == PW'(M - 1)) && (q == PW'(QPEN));
                  bus.img_addr <= img_at(k, p, l, q + PW'(1));
                  bus.ker_addr <= ker_at(p, q + PW'(1));
               end
            end
            DRAIN: begin
               if (d == DW'(DLAST)) begin
                  state         <= HOLD;
                  bus.res_valid <= 1'b1;
                  bus.res_row   <= k;
                  bus.res_col   <= l;
               end else begin
                  d <= d + DW'(1);
               end
            end
            HOLD: begin
               if (bus.res_ready) begin
                  bus.res_valid <= 1'b0;
                  p             <= '0;
                  q             <= '0;
                  if (l < RW'(WMAX)) begin
                     state         <= RUN;
                     l             <= l + RW'(1);
                     bus.tap_en    <= 1'b1;
                     bus.tap_first <= 1'b1;
                     bus.tap_last  <= (M == 1);
                     bus.img_addr  <= img_at(k, '0, l + RW'(1), '0);
                     bus.ker_addr  <= '0;
                  end else if (k < RW'(WMAX)) begin
                     state         <= RUN;
                     k             <= k + RW'(1);
                     l             <= '0;
                     bus.tap_en    <= 1'b1;
                     bus.tap_first <= 1'b1;
                     bus.tap_last  <= (M == 1);
                     bus.img_addr  <= img_at(k + RW'(1), '0, '0, '0);
                     bus.ker_addr  <= '0;
                  end else begin
                     state    <= DONE;
                     bus.done <= 1'b1;
                  end
               end
            end
            DONE: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench: vector table, directed corner sequences and a randomized pass
// on a 5x5/3x3/LAT=2 instance, plus a degenerate 3x3/3x3/LAT=0 instance.
module tb_conv_seq_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   conv_seq_if #(.N(5), .M(3)) ia ();
   conv_seq_if #(.N(3), .M(3)) ib ();

   conv_seq_ctrl #(.N(5), .M(3), .LAT(2)) dut_a (.clk(clk), .rst(rst), .bus(ia));
   conv_seq_ctrl #(.N(3), .M(3), .LAT(0)) dut_b (.clk(clk), .rst(rst), .bus(ib));

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Reference model: every tap and result of one pass, enumerated from the window/tap rules.
   int q_img[$];
   int q_ker[$];
   int q_fl[$];
   int q_res[$];

   task automatic build_model(input int n, input int m);
      q_img.delete(); q_ker.delete(); q_fl.delete(); q_res.delete();
      for (int k = 0; k <= n - m; k++)
         for (int l = 0; l <= n - m; l++) begin
            for (int p = 0; p < m; p++)
               for (int q = 0; q < m; q++) begin
                  q_img.push_back((k + p) * n + (l + q));
                  q_ker.push_back(p * m + q);
                  q_fl.push_back(((p == 0 && q == 0) ? 2 : 0) + ((p == m - 1 && q == m - 1) ? 1 : 0));
               end
            q_res.push_back(k * 100 + l);
         end
   endtask

   bit mon_on = 1'b0;
   bit pv, pr;
   int prow, pcol;
   int done_seen;

   always @(negedge clk) begin
      if (mon_on) begin
         if (pv && !pr) begin
            chk("stall_valid", int'(ia.res_valid), 1);
            chk("stall_row", int'(ia.res_row), prow);
            chk("stall_col", int'(ia.res_col), pcol);
            chk("stall_no_tap", int'(ia.tap_en), 0);
         end
         if (ia.tap_en) begin
            if (q_img.size() == 0) chk("tap_extra", 1, 0);
            else begin
               chk("tap_img", int'(ia.img_addr), q_img.pop_front());
               chk("tap_ker", int'(ia.ker_addr), q_ker.pop_front());
               chk("tap_first_last", int'({ia.tap_first, ia.tap_last}), q_fl.pop_front());
            end
         end
         if (ia.res_valid && ia.res_ready) begin
            if (q_res.size() == 0) chk("res_extra", 1, 0);
            else chk("res_coord", int'(ia.res_row) * 100 + int'(ia.res_col), q_res.pop_front());
         end
         if (ia.done) begin
            chk("done_all_taps", q_img.size(), 0);
            chk("done_all_res", q_res.size(), 0);
            done_seen++;
         end
         pv   = ia.res_valid;
         pr   = ia.res_ready;
         prow = int'(ia.res_row);
         pcol = int'(ia.res_col);
      end
   end

   typedef struct {
      logic start;
      logic rdy;
      logic busy;
      logic en;
      logic first;
      logic last;
      int   img;
      int   ker;
      logic rv;
   } vec_t;

   vec_t vec[13];

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      ia.start = 1'b0; ia.res_ready = 1'b1;
      ib.start = 1'b0; ib.res_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic chk_reset_a(input string tag);
      chk({tag, "_busy"}, int'(ia.busy), 0);
      chk({tag, "_done"}, int'(ia.done), 0);
      chk({tag, "_tap"}, int'({ia.tap_en, ia.tap_first, ia.tap_last}), 0);
      chk({tag, "_rv"}, int'(ia.res_valid), 0);
      chk({tag, "_addr"}, int'(ia.img_addr) + int'(ia.ker_addr), 0);
      chk({tag, "_rc"}, int'(ia.res_row) + int'(ia.res_col), 0);
   endtask

   initial begin
      int cyc, nres, vcnt, bad, found, vcyc;

      vec[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,  0, 0, 1'b0};
      vec[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,  1, 1, 1'b0};
      vec[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,  2, 2, 1'b0};
      vec[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,  5, 3, 1'b0};
      vec[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,  6, 4, 1'b0};
      vec[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,  7, 5, 1'b0};
      vec[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10, 6, 1'b0};
      vec[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11, 7, 1'b0};
      vec[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12, 8, 1'b0};
      vec[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12, 8, 1'b0};
      vec[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12, 8, 1'b0};
      vec[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12, 8, 1'b1};
      vec[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,  1, 0, 1'b0};

      rst = 1'b1;
      do_reset();
      chk_reset_a("rst_a");
      chk("rst_b_busy", int'(ib.busy), 0);
      chk("rst_b_tap", int'({ib.tap_en, ib.res_valid, ib.done}), 0);

      // First window of a pass, cycle by cycle.
      for (int i = 0; i < 13; i++) begin
         ia.start = vec[i].start;
         ia.res_ready = vec[i].rdy;
         @(negedge clk);
         chk($sformatf("vec%0d_busy", i), int'(ia.busy), int'(vec[i].busy));
         chk($sformatf("vec%0d_tap", i), int'({ia.tap_en, ia.tap_first, ia.tap_last}),
             int'({vec[i].en, vec[i].first, vec[i].last}));
         chk($sformatf("vec%0d_img", i), int'(ia.img_addr), vec[i].img);
         chk($sformatf("vec%0d_ker", i), int'(ia.ker_addr), vec[i].ker);
         chk($sformatf("vec%0d_rv", i), int'(ia.res_valid), int'(vec[i].rv));
         if (vec[i].rv) chk($sformatf("vec%0d_rc", i), int'(ia.res_row) * 100 + int'(ia.res_col), 0);
      end

      // Full pass with res_ready high: length and result order.
      do_reset();
      ia.start = 1'b1;
      @(negedge clk);
      ia.start = 1'b0;
      cyc = 1; nres = 0;
      while (!ia.done && cyc < 500) begin
         if (ia.res_valid) begin
            chk("order_rc", int'(ia.res_row) * 100 + int'(ia.res_col), (nres / 3) * 100 + (nres % 3));
            nres++;
         end
         @(negedge clk);
         cyc++;
      end
      chk("pass_len_a", cyc, 109);
      chk("n_results_a", nres, 9);
      @(negedge clk);
      chk("busy_after_a", int'(ia.busy), 0);
      chk("done_pulse_a", int'(ia.done), 0);

      // Five-cycle stall on result (0,1).
      do_reset();
      ia.start = 1'b1;
      @(negedge clk);
      ia.start = 1'b0;
      cyc = 0; vcnt = 0; bad = 0;
      while (!ia.done && cyc < 1000) begin
         if (ia.res_valid && ia.res_row == 0 && ia.res_col == 1) begin
            vcnt++;
            ia.res_ready = (vcnt >= 6);
         end
         if (ia.res_valid && ia.tap_en) bad++;
         @(negedge clk);
         cyc++;
      end
      ia.res_ready = 1'b1;
      chk("stall_valid_cycles", vcnt, 6);
      chk("stall_tap_overlap", bad, 0);
      chk("stall_pass_done", int'(ia.done), 1);

      // Reset during RUN of window (1,1), then restart.
      do_reset();
      ia.start = 1'b1;
      @(negedge clk);
      ia.start = 1'b0;
      found = 0;
      for (int i = 0; i < 500 && found == 0; i++) begin
         if (ia.tap_en && ia.tap_first && ia.img_addr == 6) found = 1;
         else @(negedge clk);
      end
      chk("win11_reached", found, 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset_a("midrun_rst");
      ia.start = 1'b1;
      @(negedge clk);
      ia.start = 1'b0;
      chk("restart_tap", int'({ia.busy, ia.tap_en, ia.tap_first}), 7);
      chk("restart_addr", int'(ia.img_addr) + int'(ia.ker_addr), 0);

      // Degenerate N=M, LAT=0 with an extra start during HOLD.
      do_reset();
      ib.start = 1'b1;
      @(negedge clk);
      ib.start = 1'b0;
      cyc = 1; nres = 0; vcyc = 0;
      while (!ib.done && cyc < 100) begin
         ib.start = 1'b0;
         if (ib.res_valid) begin
            nres++;
            vcyc = cyc;
            chk("b_rc", int'(ib.res_row) + int'(ib.res_col), 0);
            ib.start = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      ib.start = 1'b0;
      chk("b_valid_cycle", vcyc, 10);
      chk("b_done_cycle", cyc, 11);
      chk("b_n_results", nres, 1);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (ib.busy || ib.tap_en) bad++;
      end
      chk("b_start_not_queued", bad, 0);

      // Start held high: back-to-back passes on the degenerate instance.
      ib.start = 1'b1;
      cyc = 0;
      while (!ib.done && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      chk("b_held_idle_busy", int'(ib.busy), 0);
      @(negedge clk);
      chk("b_held_restart", int'({ib.busy, ib.tap_en, ib.tap_first}), 7);
      ib.start = 1'b0;

      // Randomized stalls and stray starts against the model.
      do_reset();
      build_model(5, 3);
      pv = 1'b0; pr = 1'b1; done_seen = 0;
      mon_on = 1'b1;
      ia.start = 1'b1;
      for (int i = 0; i < 3000 && done_seen == 0; i++) begin
         @(posedge clk);
         #2;
         ia.start = ia.busy && ($urandom_range(0, 7) == 0);
         ia.res_ready = ($urandom_range(0, 3) != 0);
      end
      ia.start = 1'b0;
      ia.res_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      mon_on = 1'b0;
      chk("rand_done", done_seen, 1);
      chk("rand_idle", int'(ia.busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
